e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit for the pipelined MIPS core. It owns the HI/LO registers and executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` with parametrised multi-cycle latencies. It reports `busy` and `md_active` so the hazard unit can stall later HI/LO-touching instructions in D. A `flush` input suppresses issue in the cycle an exception or interrupt is taken, for precise exceptions.

## Interface

Parameters:
- `WIDTH`, default 32: operand and HI/LO width.
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`. Must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`. Must be ≥1.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `md_op`  in  3  operation in E:
  - 0 = none, 1 = mult, 2 = multu, 3 = div, 4 = divu, 5 = mthi, 6 = mtlo.
  - 7 = none.
- `flush`  in  1  exception/interrupt taken this cycle; the op in E is cancelled.
- `rs_val`  in  WIDTH  forwarded rs operand (dividend, multiplicand, or mthi/mtlo data).
- `rt_val`  in  WIDTH  forwarded rt operand.
- `busy`  out  1  an operation is in progress.
- `md_active`  out  1  combinational: `busy | (md_op in 1..4 & !flush)`. The hazard unit stalls on this.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation

- **Issue.** An op is accepted at a rising edge when `md_op` ≠ 0, `flush` = 0 and `busy` = 0.
  - With `flush` = 1, nothing is latched and no state changes.
  - With `busy` = 1, `md_op` is ignored. This cannot occur in a correct pipeline; the bench checks it is ignored.
- **Start (ops 1–4).**
  - Compute the 2·WIDTH result from `rs_val`/`rt_val` and latch it into pending registers `p_hi`/`p_lo`.
  - Load the down-counter with `MULT_CYCLES` or `DIV_CYCLES`. Counter width is `$clog2(max+1)`.
  - Set `busy` = 1.
- **Multiply.**
  - `mult`: signed WIDTH×WIDTH product.
  - `multu`: unsigned WIDTH×WIDTH product.
  - `p_hi` = product[2W-1:W], `p_lo` = product[W-1:0].
- **Divide.**
  - `div` (signed): quotient to `p_lo`, remainder to `p_hi`. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - `divu`: unsigned quotient and remainder.
  - Signed MIN/−1 gives `p_lo` = MIN (wrap) and `p_hi` = 0.
- **Divide by zero** (`rt_val` = 0, `div` or `divu`). The busy period runs normally, but HI/LO are left unchanged at completion. A sticky internal `dz` flag records this.
- **Counting.** Each cycle with `busy` = 1, the counter decrements. At the edge where the counter goes 1→0:
  - `hi` ← `p_hi` and `lo` ← `p_lo`, unless `dz`.
  - `busy` ← 0 and `dz` ← 0.
- **mthi / mtlo.** Single cycle, no busy. `hi` (or `lo`) ← `rs_val` at the issuing edge.
- **Flush during busy.** Has no effect; the in-flight op completes. It was architecturally committed before the exception.
- **Reset.** Synchronous. `hi` = 0, `lo` = 0, `busy` = 0, counter = 0, `p_hi` = `p_lo` = 0, `dz` = 0. Reset mid-operation aborts it; no HI/LO write occurs.

## Timing

- Issue edge t0. `busy` is high from after t0 through the cycle before edge t0+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- At edge t0+N: `busy` falls and `hi`/`lo` update. The new values are visible in the same cycle `busy` is low.
- A back-to-back issue is legal in the cycle `busy` first reads 0.
- `md_active` rises combinationally in the issue cycle, so an `mfhi` in D is stalled at once.
- mthi/mtlo: the new value is visible on `hi`/`lo` the cycle after the issuing edge.
- `hi`, `lo` and `busy` are registered outputs. `md_active` is the only combinational output.

## Test plan

- **mult.** WIDTH = 32, MULT_CYCLES = 5. mult rs = 0xFFFFFFFD (−3), rt = 5.
  - `busy` is high for exactly 5 cycles.
  - Then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1.
  - `hi`/`lo` keep their old values while busy.
- **divu and div.** DIV_CYCLES = 10.
  - divu 7/2 → `lo` = 3, `hi` = 1 after 10 busy cycles.
  - div −7/2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- **Divide by zero.** Preload `hi` = 0x11, `lo` = 0x22 via mthi/mtlo, then issue div 5/0.
  - `busy` is high for 10 cycles.
  - `hi`/`lo` remain 0x11/0x22.
- **Flush.**
  - mult with `flush` = 1 → `busy` stays 0, `hi`/`lo` unchanged, `md_active` = 0.
  - mtlo with `flush` = 1 → `lo` unchanged.
- **Busy interactions.**
  - Issue multu 0xFFFFFFFF×2; during busy, drive mthi 0xAA and div.
  - Both are ignored; the result is `hi` = 1, `lo` = 0xFFFFFFFE.
  - Flush asserted mid-busy does not cancel the multu.
- **Reset mid-operation.** Assert `reset` at cycle 3 of a div.
  - Next cycle: `busy` = 0, `hi` = `lo` = 0.
  - No later writeback.
  - A fresh mult issued immediately completes correctly.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div with fixed multi-cycle
// latency and reports busy/md_active for the hazard unit.
module e_mdu #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       md_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             md_active,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6,
    OpRsvd  = 3'd7
  } md_op_e;

  md_op_e            op;
  logic [CntW-1:0]   cnt;
  logic [WIDTH-1:0]  p_hi, p_lo;
  logic              dz;

  logic               is_signed, is_mul, is_div;
  logic [2*WIDTH-1:0] mul_a, mul_b, product;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign op        = md_op_e'(md_op);
  assign is_signed = (op == OpMult) || (op == OpDiv);
  assign is_mul    = (op == OpMult) || (op == OpMultu);
  assign is_div    = (op == OpDiv)  || (op == OpDivu);
  assign md_active = busy | ((is_mul | is_div) & ~flush);

  // One 2W multiplier serves both flavours; only the operand extension differs.
  assign mul_a   = {{WIDTH{is_signed & rs_val[WIDTH-1]}}, rs_val};
  assign mul_b   = {{WIDTH{is_signed & rt_val[WIDTH-1]}}, rt_val};
  assign product = mul_a * mul_b;

  // Signed divide via magnitudes; MIN/-1 falls out as MIN rem 0 with no special case.
  assign neg_a  = is_signed & rs_val[WIDTH-1];
  assign neg_b  = is_signed & rt_val[WIDTH-1];
  assign a_mag  = neg_a ? -rs_val : rs_val;
  assign b_mag  = neg_b ? -rt_val : rt_val;
  assign b_safe = (rt_val == '0) ? WIDTH'(1) : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (neg_a ^ neg_b) ? -q_mag : q_mag;
  assign rem    = neg_a ? -r_mag : r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      dz   <= 1'b0;
    end else if (busy) begin
      // New ops and flush are both ignored while an op is in flight.
      cnt <= cnt - CntW'(1);
      if (cnt == CntW'(1)) begin
        busy <= 1'b0;
        dz   <= 1'b0;
        if (!dz) begin
          hi <= p_hi;
          lo <= p_lo;
        end
      end
    end else if (!flush) begin
      case (op)
        OpMult, OpMultu: begin
          p_hi <= product[2*WIDTH-1:WIDTH];
          p_lo <= product[WIDTH-1:0];
          cnt  <= CntW'(MULT_CYCLES);
          busy <= 1'b1;
          dz   <= 1'b0;
        end
        OpDiv, OpDivu: begin
          p_hi <= rem;
          p_lo <= quot;
          cnt  <= CntW'(DIV_CYCLES);
          busy <= 1'b1;
          dz   <= (rt_val == '0);
        end
        OpMthi: hi <= rs_val;
        OpMtlo: lo <= rs_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: a vector table of single ops plus hand-written
// sequences for flush, busy interference and reset mid-operation.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic        flush;
  logic [31:0] rs_val, rt_val;
  logic        busy, md_active;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_op     (md_op),
    .flush     (flush),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .md_active (md_active),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts cycles busy reads 1, bounded so a stuck busy shows up as a wrong count.
  task automatic run_busy(output int n);
    n = 0;
    for (int i = 0; i < 64 && busy; i++) begin
      n++;
      tick();
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    md_op  = op;
    rs_val = rs;
    rt_val = rt;
    tick();
    md_op  = 3'd0;
  endtask

  int n;
  logic [31:0] prev_hi, prev_lo;

  initial begin
    vecs[0] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1] = '{3'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
    vecs[4] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[5] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[6] = '{3'd5, 32'h11,       32'd0,        32'h11,       32'hFFFFFFFD, 0};
    vecs[7] = '{3'd6, 32'h22,       32'd0,        32'h11,       32'h22,       0};
    vecs[8] = '{3'd3, 32'd5,        32'd0,        32'h11,       32'h22,       10};
    vecs[9] = '{3'd4, 32'd5,        32'd0,        32'h11,       32'h22,       10};

    reset = 1'b1; md_op = 3'd0; flush = 1'b0; rs_val = '0; rt_val = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_md_active", {31'd0, md_active}, 32'd0);

    prev_hi = 32'd0;
    prev_lo = 32'd0;
    for (int i = 0; i < 10; i++) begin
      md_op = vecs[i].op; rs_val = vecs[i].rs; rt_val = vecs[i].rt;
      #1;
      check($sformatf("v%0d_md_active", i), {31'd0, md_active},
            {31'd0, (vecs[i].op >= 3'd1 && vecs[i].op <= 3'd4)});
      tick();
      md_op = 3'd0;
      if (vecs[i].cycles > 0) begin
        check($sformatf("v%0d_hold_hi", i), hi, prev_hi);
        check($sformatf("v%0d_hold_lo", i), lo, prev_lo);
      end
      run_busy(n);
      check($sformatf("v%0d_cycles", i), n, vecs[i].cycles);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      prev_hi = vecs[i].exp_hi;
      prev_lo = vecs[i].exp_lo;
    end

    // Flushed mult and mtlo must leave no trace.
    md_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4; flush = 1'b1;
    #1;
    check("flush_md_active", {31'd0, md_active}, 32'd0);
    tick();
    check("flush_mult_busy", {31'd0, busy}, 32'd0);
    check("flush_mult_hi", hi, 32'h11);
    check("flush_mult_lo", lo, 32'h22);
    md_op = 3'd6; rs_val = 32'h99;
    tick();
    flush = 1'b0; md_op = 3'd0;
    tick();
    check("flush_mtlo_lo", lo, 32'h22);

    // Ops and flush arriving while busy are ignored.
    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    check("bi_busy", {31'd0, busy}, 32'd1);
    md_op = 3'd5; rs_val = 32'hAA; tick();
    md_op = 3'd3; rs_val = 32'd5; rt_val = 32'd1; tick();
    md_op = 3'd0; flush = 1'b1;
    #1;
    check("bi_md_active", {31'd0, md_active}, 32'd1);
    tick();
    flush = 1'b0;
    run_busy(n);
    check("bi_cycles", n + 3, 32'd5);
    check("bi_hi", hi, 32'd1);
    check("bi_lo", lo, 32'hFFFFFFFE);
    tick(); tick();
    check("bi_idle_busy", {31'd0, busy}, 32'd0);
    check("bi_idle_hi", hi, 32'd1);

    // Reset in the third busy cycle of a div aborts it.
    issue(3'd3, 32'd100, 32'd7);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    repeat (15) tick();
    check("rst_late_busy", {31'd0, busy}, 32'd0);
    check("rst_late_hi", hi, 32'd0);
    check("rst_late_lo", lo, 32'd0);
    issue(3'd1, 32'd6, 32'd7);
    run_busy(n);
    check("rst_mult_cycles", n, 32'd5);
    check("rst_mult_hi", hi, 32'd0);
    check("rst_mult_lo", lo, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
